// File: rtl/dmem_responder.sv
// dmem_responder: target end of the core's load/store port, backed by a
// word-organised on-chip RAM. One request in flight at a time; the response
// appears a fixed LATENCY cycles after the accept edge and is held until taken.
// Optional build macro: DMEM_MISALIGN_TRAP_EN (misaligned half/word -> error
// instead of masking the low address bits to natural alignment).
module dmem_responder #(
    parameter int          DEPTH_WORDS = 1024,
    parameter logic [31:0] BASE_ADDR   = 32'h8000_0000,
    parameter int          LATENCY     = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_we,
    input  logic [1:0]  req_size,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        resp_valid,
    input  logic        resp_ready,
    output logic [31:0] resp_rdata,
    output logic        resp_err
);

    localparam int          IDX_W       = $clog2(DEPTH_WORDS);
    localparam int          CNT_W       = $clog2(LATENCY + 1);
    localparam logic [31:0] RANGE_BYTES = 32'(DEPTH_WORDS * 4);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_RESP = 2'd2
    } state_e;

    state_e             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [31:0]        rdata_q, rdata_d;
    logic               err_q, err_d;

    logic [31:0]        mem [DEPTH_WORDS];

    logic               accept;
    logic [31:0]        off;
    logic               in_range;
    logic               misaligned;
    logic               dec_err;
    logic [1:0]         lo;
    logic [1:0]         ea_lo;
    logic [IDX_W-1:0]   idx;
    logic [3:0]         be;
    logic [31:0]        wdata_sh;
    logic [31:0]        rword;
    logic [31:0]        rshift;
    logic [31:0]        rmask;
    logic [31:0]        load_data;

    assign accept     = req_valid & req_ready;
    assign req_ready  = (state_q == ST_IDLE);
    assign resp_valid = (state_q == ST_RESP);
    assign resp_rdata = rdata_q;
    assign resp_err   = err_q;

    // Address decode, range/size/alignment checks and lane steering
    always_comb begin
        off        = req_addr - BASE_ADDR;   // wraps huge when below base
        in_range   = (off < RANGE_BYTES);
        lo         = req_addr[1:0];
        misaligned = ((req_size == 2'd1) && lo[0]) ||
                     ((req_size == 2'd2) && (lo != 2'd0));
`ifdef DMEM_MISALIGN_TRAP_EN
        dec_err    = !in_range || (req_size == 2'd3) || misaligned;
        ea_lo      = lo;
`else
        dec_err    = !in_range || (req_size == 2'd3);
        case (req_size)
            2'd1:    ea_lo = {lo[1], 1'b0};
            2'd2:    ea_lo = 2'd0;
            default: ea_lo = lo;
        endcase
`endif
        idx = off[IDX_W+1:2];
        case (req_size)
            2'd0:    be = 4'b0001 << ea_lo;
            2'd1:    be = 4'b0011 << ea_lo;
            2'd2:    be = 4'b1111;
            default: be = 4'b0000;
        endcase
        case (req_size)
            2'd0:    rmask = 32'h0000_00FF;
            2'd1:    rmask = 32'h0000_FFFF;
            default: rmask = 32'hFFFF_FFFF;
        endcase
        wdata_sh  = req_wdata << {ea_lo, 3'b000};
        rword     = mem[idx];
        rshift    = rword >> {ea_lo, 3'b000};
        load_data = dec_err ? 32'h0 : (rshift & rmask);
    end

    // RAM byte-lane write, committed on the accept edge; never cleared by reset
    always_ff @(posedge clk) begin
        if (accept && req_we && !dec_err) begin
            for (int b = 0; b < 4; b++) begin
                if (be[b]) mem[idx][8*b +: 8] <= wdata_sh[8*b +: 8];
            end
        end
    end

    // State, latency counter and response registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            rdata_q <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            rdata_q <= rdata_d;
            err_q   <= err_d;
        end
    end

    // Next-state: accept -> count out latency -> hold response until taken
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        rdata_d = rdata_q;
        err_d   = err_q;
        case (state_q)
            ST_IDLE: begin
                if (accept) begin
                    state_d = ST_WAIT;
                    cnt_d   = '0;
                    rdata_d = req_we ? 32'h0 : load_data;
                    err_d   = dec_err;
                end
            end
            ST_WAIT: begin
                if (cnt_q == CNT_W'(LATENCY - 1)) state_d = ST_RESP;
                else                              cnt_d   = cnt_q + CNT_W'(1);
            end
            ST_RESP: begin
                if (resp_ready) state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

endmodule
